// File: rtl/rom_image_writer_pkg.sv
// Shared types and default geometry for the 16x8 ROM image writer and its read path.
package rom_image_writer_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_STROBE,
    ST_RDBK,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rom_image_addr_ctr.sv
// Wrapping write address plus words-written count, with load, increment and terminal-count flag.
module rom_image_addr_ctr
  import rom_image_writer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W:0]   count_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (load_i) begin
      addr_d  = START;
      count_d = '0;
    end else if (inc_i) begin
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign addr_o  = addr_q;
  assign count_o = count_q;
  // The word currently being strobed is the final one of the load.
  assign last_o  = (count_q == LAST_CNT);

endmodule

// File: rtl/rom_image_writer.sv
// Programs a byte stream into sequential addresses of a 16x8 memory image.
// Optional readback verify of every word: define ROM_IMAGE_WRITER_VERIFY_EN.
module rom_image_writer
  import rom_image_writer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_ce,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err
);

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q, ce_q, en_q, busy_q, done_q;
  logic              ctr_load, ctr_inc, ctr_last;

  assign ctr_load = start && (state_q == ST_IDLE || state_q == ST_DONE);
`ifdef ROM_IMAGE_WRITER_VERIFY_EN
  assign ctr_inc  = (state_q == ST_CHECK);
`else
  assign ctr_inc  = (state_q == ST_STROBE);
`endif

  rom_image_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .START_ADDR(START_ADDR)
  ) u_addr_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (ctr_load),
    .inc_i  (ctr_inc),
    .addr_o (mem_addr),
    .count_o(wr_count),
    .last_o (ctr_last)
  );

`ifdef ROM_IMAGE_WRITER_VERIFY_EN
  logic err_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      we_q    <= 1'b0;
      ce_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ROM_IMAGE_WRITER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy_q  <= 1'b1;
            ce_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef ROM_IMAGE_WRITER_VERIFY_EN
            err_q   <= 1'b0;
`endif
            state_q <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            data_q  <= in_data;
            we_q    <= 1'b1;
            state_q <= ST_STROBE;
          end
        end
`ifdef ROM_IMAGE_WRITER_VERIFY_EN
        ST_STROBE: begin
          we_q    <= 1'b0;
          en_q    <= 1'b1;
          state_q <= ST_RDBK;
        end
        ST_RDBK: state_q <= ST_CHECK;
        ST_CHECK: begin
          en_q <= 1'b0;
          if (mem_q != data_q) err_q <= 1'b1;
          if (ctr_last) begin
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_ACCEPT;
          end
        end
`else
        ST_STROBE: begin
          we_q <= 1'b0;
          if (ctr_last) begin
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_ACCEPT;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ROM_IMAGE_WRITER_VERIFY_EN
  assign err = err_q;
`else
  logic unused_mem_q;
  assign unused_mem_q = ^mem_q;
  assign err          = 1'b0;
`endif

  assign in_ready = (state_q == ST_ACCEPT);
  assign mem_data = data_q;
  assign mem_we   = we_q;
  assign mem_ce   = ce_q;
  assign mem_en   = en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
